cache_mem_arbiter: RTL and testbench
====================================

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL use one clock and one reset: reset is synchronous and active-high (ports clk, rst).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 rd_req  input  1  line-refill request from the read controller; held high until done.
REQ-005 rd_addr  input  32  refill address; bits [3:0] ignored.
REQ-006 rd_wait  output  1  high while rd_req pending; low for exactly the RD_DONE cycle.
REQ-007 rd_line  output  128  assembled line; word k at bits [32k+31:32k]; valid in RD_DONE cycle.
REQ-008 wr_req  input  1  write-through request from cache_write; held high until done.
REQ-009 wr_addr  input  32  write address.
REQ-010 wr_in  input  32  write data.
REQ-011 wr_type  input  `CACHE_TYPE_BITS  access type, passed to memory unchanged.
REQ-012 wr_wait  output  1  high while wr_req pending; low for exactly the WR_DONE cycle.
REQ-013 D_req, D_write  output  1 each  memory request and write strobe.
REQ-014 D_addr, D_in  output  32 each  memory address and write data.
REQ-015 D_type  output  `CACHE_TYPE_BITS  memory access type.
REQ-016 D_wait  input  1  memory busy; a beat completes in a cycle with D_req=1 and D_wait=0.
REQ-017 D_out  input  32  memory read data, valid in the completing cycle.

Function
REQ-018 SHALL implement states IDLE, RD_BURST, WR_SINGLE, RD_DONE, WR_DONE.
REQ-019 IDLE: D_req=0, D_write=0, D_addr=0, D_in=0, D_type=0.
REQ-020 IDLE, only rd_req high: next state RD_BURST; capture rd_addr[31:4] and clear beat counter.
REQ-021 IDLE, only wr_req high: next state WR_SINGLE; capture wr_addr, wr_in, wr_type.
REQ-022 IDLE, both requests high: grant the requester opposite to last_grant; last_grant updates on every grant.
REQ-023 RD_BURST: D_req=1, D_write=0, D_type=`CACHE_WORD, D_addr={captured[31:4], cnt, 2'b00}.
REQ-024 RD_BURST, on each completing beat: store D_out into rd_line word cnt and increment cnt (2 bits).
REQ-025 RD_BURST: completing beat with cnt=3 goes to RD_DONE; otherwise the state is held.
REQ-026 D_req SHALL remain high across beats; there is no idle cycle between beats.
REQ-027 WR_SINGLE: D_req=1, D_write=1, D_addr/D_in/D_type from captured registers.
REQ-028 WR_SINGLE: completing beat goes to WR_DONE.
REQ-029 RD_DONE and WR_DONE: D_req=0; drive the matching wait low for one cycle; always return to IDLE.
REQ-030 Requests are not sampled in the DONE states; requester deasserts req after the done cycle.
REQ-031 Withdrawal of a granted req is illegal; the arbiter completes the transaction and still issues the done cycle.
REQ-032 The ungranted requester's wait SHALL stay high while its req is high.
REQ-033 Latency: D_req rises 1 cycle after req is sampled in IDLE; minimum read 6 cycles req-to-done; minimum write 3 cycles.

Reset
REQ-034 rst at any cycle, including mid-burst, SHALL on the next edge force:
- state=IDLE, cnt=0, last_grant=WR (read wins the first tie)
- rd_line=0 and captured registers=0
- all D_* outputs 0, both waits following their req.

Structure
REQ-035 State encoding and `CACHE_* type codes SHALL live in shared def.svh; no state literals in the module.
REQ-036 Single flat module; no sub-module (arbitration is two-way, line assembly is one 128-bit register).

Verification
REQ-037 rd_req, rd_addr=0x0000_1234, D_wait=0 -> D_addr 0x1230, 0x1234, 0x1238, 0x123C on consecutive cycles; rd_line={D_out3..D_out0}; rd_wait low 1 cycle.
REQ-038 wr_req, wr_addr=0x40, wr_in=0xDEADBEEF, wr_type=`CACHE_BYTE, D_wait high 3 cycles -> D_req/D_write held 4 cycles, stable fields; wr_wait low once.
REQ-039 rd_req and wr_req both rise after reset -> read served first, then write; next tie serves write first.
REQ-040 wr_req rises during read beat 2 -> write starts only after RD_DONE; wr_wait high throughout.
REQ-041 rst asserted at read beat 2 -> next cycle IDLE, D_req=0, rd_line=0; new read restarts at word 0.

Source files
------------

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and codes for the cache-to-memory arbiter: FSM states,
// access-type codes, captured write command and beat address helper.
package cache_mem_arbiter_pkg;

    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned LINE_WORDS      = 4;
    localparam int unsigned LINE_W          = WORD_W * LINE_WORDS;
    localparam int unsigned BEAT_W          = 2;
    localparam int unsigned OFFSET_W        = 4;
    localparam int unsigned LINE_ADDR_W     = ADDR_W - OFFSET_W;
    localparam int unsigned CACHE_TYPE_BITS = 2;

    typedef logic [CACHE_TYPE_BITS-1:0] cache_type_t;

    localparam cache_type_t CACHE_NONE = 2'd0;
    localparam cache_type_t CACHE_BYTE = 2'd1;
    localparam cache_type_t CACHE_HALF = 2'd2;
    localparam cache_type_t CACHE_WORD = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_BURST,
        ST_WR_SINGLE,
        ST_RD_DONE,
        ST_WR_DONE
    } state_t;

    typedef enum logic {
        GRANT_RD,
        GRANT_WR
    } grant_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
        cache_type_t       typ;
    } wr_cmd_t;

    // Word-aligned address of beat `beat` within the captured line.
    function automatic logic [ADDR_W-1:0] beat_addr(
        input logic [LINE_ADDR_W-1:0] line_addr,
        input logic [BEAT_W-1:0]      beat
    );
        return {line_addr, beat, 2'b00};
    endfunction

endpackage

// File: rtl/cache_mem_arbiter.sv
// Two-way arbiter between the line-refill reader and the write-through writer
// sharing one memory port; reads are 4-beat bursts, writes are single beats.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       rd_req,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic                       rd_wait,
    output logic [LINE_W-1:0]          rd_line,

    input  logic                       wr_req,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [WORD_W-1:0]          wr_in,
    input  logic [CACHE_TYPE_BITS-1:0] wr_type,
    output logic                       wr_wait,

    output logic                       D_req,
    output logic                       D_write,
    output logic [ADDR_W-1:0]          D_addr,
    output logic [WORD_W-1:0]          D_in,
    output logic [CACHE_TYPE_BITS-1:0] D_type,
    input  logic                       D_wait,
    input  logic [WORD_W-1:0]          D_out
);

    state_t                 state_q;
    state_t                 state_d;
    logic [BEAT_W-1:0]      cnt_q;
    grant_t                 last_grant_q;
    logic [LINE_ADDR_W-1:0] rd_base_q;
    wr_cmd_t                wr_cmd_q;
    logic [LINE_W-1:0]      rd_line_q;

    logic grant_rd_c;
    logic grant_wr_c;
    logic beat_done_c;
    logic unused_offset_bits;

    assign unused_offset_bits = ^rd_addr[OFFSET_W-1:0];

    // On a tie the side that did not win last time is granted.
    assign grant_rd_c  = rd_req & (~wr_req | (last_grant_q == GRANT_WR));
    assign grant_wr_c  = wr_req & ~grant_rd_c;
    assign beat_done_c = ~D_wait;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_rd_c) begin
                    state_d = ST_RD_BURST;
                end else if (grant_wr_c) begin
                    state_d = ST_WR_SINGLE;
                end
            end
            ST_RD_BURST: begin
                if (beat_done_c && (cnt_q == BEAT_W'(LINE_WORDS - 1))) begin
                    state_d = ST_RD_DONE;
                end
            end
            ST_WR_SINGLE: begin
                if (beat_done_c) begin
                    state_d = ST_WR_DONE;
                end
            end
            ST_RD_DONE:   state_d = ST_IDLE;
            ST_WR_DONE:   state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Memory-port drive decoded from the current state only.
    always_comb begin
        D_req   = 1'b0;
        D_write = 1'b0;
        D_addr  = '0;
        D_in    = '0;
        D_type  = CACHE_NONE;
        case (state_q)
            ST_RD_BURST: begin
                D_req  = 1'b1;
                D_type = CACHE_WORD;
                D_addr = beat_addr(rd_base_q, cnt_q);
            end
            ST_WR_SINGLE: begin
                D_req   = 1'b1;
                D_write = 1'b1;
                D_addr  = wr_cmd_q.addr;
                D_in    = wr_cmd_q.data;
                D_type  = wr_cmd_q.typ;
            end
            default: begin
            end
        endcase
    end

    // A requester sees its wait drop only in its own done cycle.
    assign rd_wait = rd_req & (state_q != ST_RD_DONE);
    assign wr_wait = wr_req & (state_q != ST_WR_DONE);
    assign rd_line = rd_line_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            last_grant_q <= GRANT_WR;
            rd_base_q    <= '0;
            wr_cmd_q     <= '0;
            rd_line_q    <= '0;
        end else begin
            if (state_q == ST_IDLE && grant_rd_c) begin
                rd_base_q    <= rd_addr[ADDR_W-1:OFFSET_W];
                cnt_q        <= '0;
                last_grant_q <= GRANT_RD;
            end else if (state_q == ST_IDLE && grant_wr_c) begin
                wr_cmd_q     <= '{addr: wr_addr, data: wr_in, typ: wr_type};
                last_grant_q <= GRANT_WR;
            end
            if (state_q == ST_RD_BURST && beat_done_c) begin
                rd_line_q[{cnt_q, 5'd0} +: WORD_W] <= D_out;
                cnt_q <= cnt_q + BEAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios with literal expectations,
// then randomized requesters and memory checked against a transaction model.
module tb_cache_mem_arbiter;
    import cache_mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_wait;
    logic [127:0] rd_line;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_in;
    logic [1:0]  wr_type;
    logic        wr_wait;
    logic        D_req;
    logic        D_write;
    logic [31:0] D_addr;
    logic [31:0] D_in;
    logic [1:0]  D_type;
    logic        D_wait;
    logic [31:0] D_out;

    always #5 clk = ~clk;

    cache_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_wait(rd_wait), .rd_line(rd_line),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_in(wr_in), .wr_type(wr_type),
        .wr_wait(wr_wait),
        .D_req(D_req), .D_write(D_write), .D_addr(D_addr), .D_in(D_in),
        .D_type(D_type), .D_wait(D_wait), .D_out(D_out)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Transaction-level model: who owns the port, how many beats have
    // completed, and whether the owner is in its one-cycle completion window.
    int          m_owner = 0;          // 0 none, 1 reader, 2 writer
    bit          m_closing = 1'b0;
    int          m_beats = 0;
    bit          m_reader_wins_tie = 1'b1;
    logic [31:0] m_rd_base = '0;
    logic [31:0] m_wr_addr = '0;
    logic [31:0] m_wr_data = '0;
    logic [1:0]  m_wr_type = '0;
    logic [31:0] m_words [4] = '{default: '0};

    always @(posedge clk) begin
        if (rst) begin
            m_owner           <= 0;
            m_closing         <= 1'b0;
            m_beats           <= 0;
            m_reader_wins_tie <= 1'b1;
            m_rd_base         <= '0;
            m_wr_addr         <= '0;
            m_wr_data         <= '0;
            m_wr_type         <= '0;
            for (int i = 0; i < 4; i++) m_words[i] <= '0;
        end else if (m_closing) begin
            m_owner   <= 0;
            m_closing <= 1'b0;
        end else if (m_owner == 0) begin
            if (rd_req && (!wr_req || m_reader_wins_tie)) begin
                m_owner           <= 1;
                m_beats           <= 0;
                m_rd_base         <= rd_addr & 32'hFFFF_FFF0;
                m_reader_wins_tie <= 1'b0;
            end else if (wr_req) begin
                m_owner           <= 2;
                m_wr_addr         <= wr_addr;
                m_wr_data         <= wr_in;
                m_wr_type         <= wr_type;
                m_reader_wins_tie <= 1'b1;
            end
        end else if (!D_wait) begin
            if (m_owner == 1) begin
                m_words[m_beats] <= D_out;
                m_beats          <= m_beats + 1;
                if (m_beats == 3) m_closing <= 1'b1;
            end else begin
                m_closing <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("m_rd_wait", 128'(rd_wait), 128'(rd_req && !(m_closing && m_owner == 1)));
            chk("m_wr_wait", 128'(wr_wait), 128'(wr_req && !(m_closing && m_owner == 2)));
            chk("m_rd_line", rd_line, {m_words[3], m_words[2], m_words[1], m_words[0]});
            chk("m_D_req", 128'(D_req), 128'(m_owner != 0 && !m_closing));
            if (m_owner == 0) begin
                chk("m_idle_D_write", 128'(D_write), 128'(1'b0));
                chk("m_idle_D_addr", 128'(D_addr), 128'(32'h0));
                chk("m_idle_D_in", 128'(D_in), 128'(32'h0));
                chk("m_idle_D_type", 128'(D_type), 128'(2'h0));
            end else if (m_closing) begin
                chk("m_done_D_write", 128'(D_write), 128'(1'b0));
            end else if (m_owner == 1) begin
                chk("m_rd_D_write", 128'(D_write), 128'(1'b0));
                chk("m_rd_D_type", 128'(D_type), 128'(CACHE_WORD));
                chk("m_rd_D_addr", 128'(D_addr), 128'(m_rd_base + 32'(m_beats * 4)));
            end else begin
                chk("m_wr_D_write", 128'(D_write), 128'(1'b1));
                chk("m_wr_D_addr", 128'(D_addr), 128'(m_wr_addr));
                chk("m_wr_D_in", 128'(D_in), 128'(m_wr_data));
                chk("m_wr_D_type", 128'(D_type), 128'(m_wr_type));
            end
        end
    end

    initial begin
        bit done_rd, done_wr;
        bit finished;
        rst = 1'b1; rd_req = 0; rd_addr = 0; wr_req = 0; wr_addr = 0;
        wr_in = 0; wr_type = 0; D_wait = 0; D_out = 0;
        @(posedge clk);
        check_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset_D_req", 128'(D_req), 128'(1'b0));
        chk("reset_rd_line", rd_line, 128'h0);
        chk("reset_rd_wait", 128'(rd_wait), 128'(1'b0));

        // Burst read at 0x1234, memory never stalls
        #1 rd_req = 1'b1; rd_addr = 32'h0000_1234; D_wait = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("burst_addr%0d", k), 128'(D_addr), 128'(32'h1230 + 32'(4 * k)));
            chk($sformatf("burst_rd_wait%0d", k), 128'(rd_wait), 128'(1'b1));
            #1 D_out = 32'hC0DE_0000 | 32'(k);
        end
        @(negedge clk);
        chk("burst_done_wait", 128'(rd_wait), 128'(1'b0));
        chk("burst_line", rd_line, 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000);
        #1 rd_req = 1'b0;
        @(negedge clk);
        chk("burst_after_D_req", 128'(D_req), 128'(1'b0));

        // Single write with three stall cycles
        #1 wr_req = 1'b1; wr_addr = 32'h40; wr_in = 32'hDEAD_BEEF;
        wr_type = CACHE_BYTE; D_wait = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("wr_D_req%0d", k), 128'(D_req), 128'(1'b1));
            chk($sformatf("wr_D_write%0d", k), 128'(D_write), 128'(1'b1));
            chk($sformatf("wr_D_addr%0d", k), 128'(D_addr), 128'(32'h40));
            chk($sformatf("wr_D_in%0d", k), 128'(D_in), 128'(32'hDEAD_BEEF));
            chk($sformatf("wr_D_type%0d", k), 128'(D_type), 128'(CACHE_BYTE));
            chk($sformatf("wr_wait%0d", k), 128'(wr_wait), 128'(1'b1));
            if (k == 3) #1 D_wait = 1'b0;
        end
        @(negedge clk);
        chk("wr_done_wait", 128'(wr_wait), 128'(1'b0));
        chk("wr_done_D_req", 128'(D_req), 128'(1'b0));
        #1 wr_req = 1'b0;

        // Simultaneous requests: reader first, then writer on the next tie
        @(negedge clk);
        #1 rd_req = 1'b1; wr_req = 1'b1; rd_addr = 32'h100; wr_addr = 32'h200;
        wr_in = 32'h5555_AAAA; wr_type = CACHE_WORD;
        @(negedge clk);
        chk("tie1_is_read", 128'(D_write), 128'(1'b0));
        chk("tie1_addr", 128'(D_addr), 128'(32'h100));
        chk("tie1_wr_wait", 128'(wr_wait), 128'(1'b1));
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("tie1_rd_done", 128'(rd_wait), 128'(1'b0));
        chk("tie1_wr_held", 128'(wr_wait), 128'(1'b1));
        @(negedge clk);
        chk("tie_gap_D_req", 128'(D_req), 128'(1'b0));
        @(negedge clk);
        chk("tie2_is_write", 128'(D_write), 128'(1'b1));
        chk("tie2_addr", 128'(D_addr), 128'(32'h200));
        @(negedge clk);
        chk("tie2_wr_done", 128'(wr_wait), 128'(1'b0));
        #1 wr_req = 1'b0;

        // Reset in the middle of a burst, then the read restarts at word 0
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_D_req", 128'(D_req), 128'(1'b0));
        chk("midrst_rd_line", rd_line, 128'h0);
        chk("midrst_rd_wait", 128'(rd_wait), 128'(1'b1));
        #1 rst = 1'b0;
        @(negedge clk);
        chk("restart_addr", 128'(D_addr), 128'(32'h100));
        chk("restart_D_req", 128'(D_req), 128'(1'b1));
        finished = 1'b0;
        for (int i = 0; i < 20 && !finished; i++) begin
            @(negedge clk);
            if (!rd_wait) finished = 1'b1;
        end
        chk("restart_completes", 128'(finished), 128'(1'b1));
        #1 rd_req = 1'b0;

        // Randomized requesters and memory
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            #1;
            done_rd = rd_req && !rd_wait;
            done_wr = wr_req && !wr_wait;
            rst    = ($urandom_range(0, 299) == 0);
            D_wait = ($urandom_range(0, 3) == 0);
            D_out  = $urandom;
            if (done_rd) begin
                rd_req  = ($urandom_range(0, 3) == 0);
                rd_addr = $urandom;
            end else if (!rd_req && $urandom_range(0, 2) == 0) begin
                rd_req  = 1'b1;
                rd_addr = $urandom;
            end
            if (done_wr) begin
                wr_req  = ($urandom_range(0, 3) == 0);
                wr_addr = $urandom;
                wr_in   = $urandom;
                wr_type = 2'($urandom_range(0, 3));
            end else if (!wr_req && $urandom_range(0, 2) == 0) begin
                wr_req  = 1'b1;
                wr_addr = $urandom;
                wr_in   = $urandom;
                wr_type = 2'($urandom_range(0, 3));
            end
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
